uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5208, giving IN_clk cycles per serial bit (9600 baud at 50 MHz); legal range 2 to 65535.
REQ-002 The block SHALL have parameter PARITY, default 0, selecting 0 = none, 1 = even, 2 = odd.
REQ-003 The block SHALL have port IN_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port IN_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port IN_data, input, 8 bits: byte to transmit.
REQ-006 The block SHALL have port IN_valid, input, 1 bit: IN_data is valid this cycle.
REQ-007 The block SHALL have port OUT_ready, output, 1 bit: the FIFO can accept a byte this cycle.
REQ-008 The block SHALL have port OUT_tx, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port OUT_busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.

Function
REQ-010 The block SHALL contain a 4-entry byte FIFO with a 3-bit occupancy count; a byte is pushed on any rising edge where IN_valid=1 and OUT_ready=1.
REQ-011 OUT_ready SHALL be registered and equal (count < 4); with count = 4, a push is refused even if a pop occurs in the same cycle.
REQ-012 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-013 IN_valid SHALL be ignored while OUT_ready=0; no data is lost or duplicated.
REQ-014 The transmit FSM SHALL have states IDLE, START, DATA, PAR and STOP.
REQ-015 IDLE -> START SHALL occur on the edge where the FIFO is non-empty; that edge pops the head byte into an 8-bit shift register and drives OUT_tx low.
REQ-016 Latency: a byte pushed into an empty FIFO with the FSM in IDLE SHALL drive OUT_tx low on the second rising edge after the accepting edge.
REQ-017 Each bit SHALL be held on OUT_tx for exactly CLKS_PER_BIT cycles, timed by a baud counter of width clog2(CLKS_PER_BIT) that reloads at every bit boundary.
REQ-018 START -> DATA SHALL occur after one bit time; DATA SHALL send 8 bits LSB first, using a 3-bit index that wraps 7 -> 0 on exit.
REQ-019 DATA SHALL go to PAR when PARITY != 0 and to STOP otherwise.
REQ-020 The PAR bit SHALL be the XOR of the 8 data bits for even parity and its inverse for odd parity.
REQ-021 STOP SHALL drive OUT_tx high for one bit time.
REQ-022 At the end of STOP, if the FIFO is non-empty, the FSM SHALL go directly to START, popping the next byte with zero idle cycles between frames; otherwise it SHALL go to IDLE.
REQ-023 Frame length SHALL be 10*CLKS_PER_BIT cycles without parity and 11*CLKS_PER_BIT cycles with parity.
REQ-024 OUT_busy SHALL be registered and equal (state != IDLE) or (count != 0).
REQ-025 OUT_tx SHALL be driven from a flop so it is glitch-free.
REQ-026 IN_data SHALL be sampled only at push; later changes to IN_data SHALL NOT affect queued bytes.

Reset
REQ-027 While IN_rst=1 at a rising edge, the block SHALL set state=IDLE, count=0, FIFO pointers=0, baud counter=0, bit index=0, OUT_tx=1, OUT_busy=0 and OUT_ready=0.
REQ-028 OUT_ready SHALL be 1 from the first edge with IN_rst=0.
REQ-029 A reset asserted mid-frame SHALL abort the frame and discard all FIFO contents, with OUT_tx high after that edge.
REQ-030 A push attempted during reset SHALL be discarded.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-031 Single byte 0xA5, PARITY=0 -> OUT_tx low 2 edges after accept; line reads 0,1,0,1,0,0,1,0,1,1 with 4 cycles each; OUT_busy falls 40 cycles after start.
REQ-032 Five back-to-back pushes 0x01-0x05 with IN_valid held high -> OUT_ready drops after the 4th accepted push (or 5th if first already popped); all five bytes are sent in order with no gap between stop and next start.
REQ-033 PARITY=1, byte 0x07 -> parity bit 1; PARITY=2, byte 0x07 -> parity bit 0; frame length 44 cycles.
REQ-034 Reset asserted during DATA bit 3 with 2 bytes queued -> next edge OUT_tx=1, OUT_busy=0, no further frames sent; OUT_ready=1 one edge after reset is released.
REQ-035 FIFO full (count=4) with a pop and IN_valid=1 in the same cycle -> push refused, count becomes 3, OUT_ready=1 on the next cycle.
REQ-036 CLKS_PER_BIT=2, byte 0xFF -> each bit lasts exactly 2 cycles; frame length is 20 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a 4-entry byte FIFO; 8 data bits, optional parity, one stop bit.
// Frames are sent back-to-back while bytes are queued.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned PARITY       = 0
) (
  input  logic       IN_clk,
  input  logic       IN_rst,
  input  logic [7:0] IN_data,
  input  logic       IN_valid,
  output logic       OUT_ready,
  output logic       OUT_tx,
  output logic       OUT_busy
);

  localparam int unsigned      BaudW   = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  localparam logic             OddPar  = (PARITY == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e           r_state;
  logic [7:0]       r_mem [4];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [2:0]       r_count;
  logic             r_ready;
  logic             r_busy;
  logic             r_pending;
  logic             r_tx;
  logic             r_par;
  logic [7:0]       r_shift;
  logic [BaudW-1:0] r_baud;
  logic [2:0]       r_idx;

  logic       w_push;
  logic       w_pop;
  logic       w_bit_end;
  logic       w_to_idle;
  logic [2:0] w_count_d;
  logic [7:0] w_head;

  always_comb begin
    w_push    = IN_valid & r_ready;
    w_bit_end = (r_baud == BaudMax);
    w_head    = r_mem[r_rd_ptr];
    w_pop     = 1'b0;
    w_to_idle = 1'b0;
    case (r_state)
      StIdle: begin
        // r_pending lags the count by one edge, giving the two-edge start latency
        w_pop     = r_pending & (r_count != 3'd0);
        w_to_idle = ~w_pop;
      end
      StStop: begin
        if (w_bit_end) begin
          w_pop     = (r_count != 3'd0);
          w_to_idle = ~w_pop;
        end
      end
      default: ;
    endcase
    w_count_d = r_count + {2'b00, w_push} - {2'b00, w_pop};
  end

  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      r_wr_ptr  <= 2'd0;
      r_rd_ptr  <= 2'd0;
      r_count   <= 3'd0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= IN_data;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_count   <= w_count_d;
      r_ready   <= (w_count_d < 3'd4);
      r_busy    <= ~w_to_idle | (w_count_d != 3'd0);
      r_pending <= (r_count != 3'd0);
    end
  end

  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_idx   <= 3'd0;
      r_tx    <= 1'b1;
      r_shift <= 8'd0;
      r_par   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_par   <= (^w_head) ^ OddPar;
            r_tx    <= 1'b0;
            r_baud  <= '0;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_idx   <= 3'd0;
            r_tx    <= r_shift[0];
            r_state <= StData;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_baud <= '0;
            r_idx  <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              if (PARITY != 0) begin
                r_tx    <= r_par;
                r_state <= StPar;
              end else begin
                r_tx    <= 1'b1;
                r_state <= StStop;
              end
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        StPar: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= StStop;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_par   <= (^w_head) ^ OddPar;
              r_tx    <= 1'b0;
              r_state <= StStart;
            end else begin
              r_tx    <= 1'b1;
              r_state <= StIdle;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign OUT_ready = r_ready;
  assign OUT_tx    = r_tx;
  assign OUT_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (CLKS_PER_BIT/PARITY = 4/0, 4/1, 4/2, 2/0),
// directed frame checks plus a random push phase decoded by a serial-line monitor on instance 0.
module tb_uart_tx_fifo;

  logic       clk;
  logic [3:0] rst;
  logic [3:0] valid;
  logic [3:0] ready;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [7:0] data [4];

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        mon_on = 1'b0;
  logic [7:0]  q_exp [$];
  int unsigned fst [64];
  int          nfr = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(0)) u_dut0 (
    .IN_clk(clk), .IN_rst(rst[0]), .IN_data(data[0]), .IN_valid(valid[0]),
    .OUT_ready(ready[0]), .OUT_tx(tx[0]), .OUT_busy(busy[0])
  );
  uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(1)) u_dut1 (
    .IN_clk(clk), .IN_rst(rst[1]), .IN_data(data[1]), .IN_valid(valid[1]),
    .OUT_ready(ready[1]), .OUT_tx(tx[1]), .OUT_busy(busy[1])
  );
  uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(2)) u_dut2 (
    .IN_clk(clk), .IN_rst(rst[2]), .IN_data(data[2]), .IN_valid(valid[2]),
    .OUT_ready(ready[2]), .OUT_tx(tx[2]), .OUT_busy(busy[2])
  );
  uart_tx_fifo #(.CLKS_PER_BIT(2), .PARITY(0)) u_dut3 (
    .IN_clk(clk), .IN_rst(rst[3]), .IN_data(data[3]), .IN_valid(valid[3]),
    .OUT_ready(ready[3]), .OUT_tx(tx[3]), .OUT_busy(busy[3])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level of frame bit b: start, 8 data LSB first, optional parity, stop.
  function automatic logic fbit(input logic [7:0] d, input int par, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && par != 0) return (^d) ^ (par == 2);
    return 1'b1;
  endfunction

  // Push one byte into an idle instance and check the whole frame cycle by cycle.
  task automatic send_and_check(input int i, input logic [7:0] d, input int par, input int cpb);
    int nb;
    nb = (par != 0) ? 11 : 10;
    check($sformatf("dut%0d_ready_pre", i), ready[i], 1);
    valid[i] = 1'b1;
    data[i]  = d;
    tick();
    valid[i] = 1'b0;
    data[i]  = 8'($urandom);
    if (i == 0) q_exp.push_back(d);
    check($sformatf("dut%0d_busy_after_push", i), busy[i], 1);
    check($sformatf("dut%0d_tx_lat0", i), tx[i], 1);
    tick();
    check($sformatf("dut%0d_tx_lat1", i), tx[i], 1);
    for (int k = 0; k < nb * cpb; k++) begin
      tick();
      check($sformatf("dut%0d_tx_c%0d", i, k), tx[i], fbit(d, par, k / cpb));
      check($sformatf("dut%0d_busy_c%0d", i, k), busy[i], 1);
    end
    tick();
    check($sformatf("dut%0d_busy_end", i), busy[i], 0);
    check($sformatf("dut%0d_tx_end", i), tx[i], 1);
  endtask

  // Serial monitor for instance 0: decodes frames and compares with accepted bytes in order.
  initial begin : mon
    logic [9:0] bits;
    logic       v;
    logic       stable;
    logic [7:0] got;
    wait (mon_on);
    forever begin
      @(negedge clk);
      if (tx[0] === 1'b0) begin
        if (nfr < 64) fst[nfr] = cyc;
        nfr++;
        for (int b = 0; b < 10; b++) begin
          stable = 1'b1;
          v      = 1'b0;
          for (int c = 0; c < 4; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) v = tx[0];
            else if (tx[0] !== v) stable = 1'b0;
          end
          bits[b] = v;
          check($sformatf("mon_bit%0d_stable", b), stable, 1);
        end
        check("mon_stop", bits[9], 1);
        got = bits[8:1];
        check("mon_frame_expected", (q_exp.size() != 0), 1);
        if (q_exp.size() != 0) check("mon_byte", got, q_exp.pop_front());
      end
    end
  end

  initial begin : main
    int unsigned a0;
    int unsigned a_last;
    int          nacc;
    int          fb;
    int          bad;
    logic        rdy;
    logic        got_rdy;

    rst   = 4'hF;
    valid = 4'h0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    valid[0] = 1'b1;
    data[0]  = 8'h5A;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i), tx[i], 1);
      check($sformatf("rst_busy%0d", i), busy[i], 0);
      check($sformatf("rst_ready%0d", i), ready[i], 0);
    end
    rst      = 4'h0;
    valid[0] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rel_ready%0d", i), ready[i], 1);
      check($sformatf("rel_busy%0d", i), busy[i], 0);
    end
    mon_on = 1'b1;
    bad = 0;
    repeat (12) begin
      tick();
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    check("rst_push_discarded", bad, 0);

    // Single byte, no parity
    send_and_check(0, 8'hA5, 0, 4);

    // Five back-to-back pushes with valid held, then a push attempt while full
    fb       = nfr;
    nacc     = 0;
    a0       = 0;
    a_last   = 0;
    valid[0] = 1'b1;
    data[0]  = 8'h01;
    for (int t = 0; t < 20 && nacc < 5; t++) begin
      rdy = ready[0];
      tick();
      if (rdy) begin
        q_exp.push_back(data[0]);
        if (nacc == 0) a0 = cyc;
        a_last = cyc;
        nacc++;
        data[0] = 8'(nacc + 1);
      end
    end
    check("t2_accepts", nacc, 5);
    check("t2_consecutive", a_last - a0, 4);
    check("t2_ready_full", ready[0], 0);
    got_rdy = 1'b0;
    for (int t = 0; t < 100 && !got_rdy; t++) begin
      tick();
      if (ready[0]) got_rdy = 1'b1;
    end
    check("t2_ready_back_cycle", cyc - a0, 42);
    tick();
    valid[0] = 1'b0;
    if (got_rdy) q_exp.push_back(8'h06);
    check("t2_full_again", ready[0], 0);
    for (int t = 0; t < 600 && busy[0]; t++) tick();
    check("t2_drain", busy[0], 0);
    check("t2_queue_empty", q_exp.size(), 0);
    check("t2_frames", nfr - fb, 6);
    check("t2_first_start", fst[fb], a0 + 2);
    for (int j = 1; j < 6; j++) begin
      check($sformatf("t2_gap%0d", j), fst[fb+j] - fst[fb+j-1], 40);
    end

    // Parity frames and a short bit time
    send_and_check(1, 8'h07, 1, 4);
    send_and_check(2, 8'h07, 2, 4);
    send_and_check(3, 8'hFF, 0, 2);

    // Reset mid-frame with two bytes still queued
    nacc     = 0;
    valid[1] = 1'b1;
    data[1]  = 8'h35;
    for (int t = 0; t < 10 && nacc < 3; t++) begin
      rdy = ready[1];
      tick();
      if (rdy) begin
        if (nacc == 0) a0 = cyc;
        nacc++;
        data[1] = (nacc == 1) ? 8'h11 : 8'h22;
      end
    end
    valid[1] = 1'b0;
    check("rst_mid_accepts", nacc, 3);
    while (cyc < a0 + 2 + 17) tick();
    check("rst_mid_pre_tx", tx[1], fbit(8'h35, 1, 4));
    rst[1] = 1'b1;
    tick();
    check("rst_mid_tx", tx[1], 1);
    check("rst_mid_busy", busy[1], 0);
    check("rst_mid_ready", ready[1], 0);
    tick();
    rst[1] = 1'b0;
    tick();
    check("rst_mid_rel_ready", ready[1], 1);
    check("rst_mid_rel_busy", busy[1], 0);
    bad = 0;
    repeat (60) begin
      tick();
      if (tx[1] !== 1'b1 || busy[1] !== 1'b0) bad++;
    end
    check("rst_mid_no_frames", bad, 0);

    // Random pushes against the ordered-byte model
    nacc = 0;
    for (int t = 0; t < 300; t++) begin
      valid[0] = ($urandom_range(0, 2) == 0);
      data[0]  = 8'($urandom);
      rdy      = ready[0] & valid[0];
      tick();
      if (rdy) begin
        q_exp.push_back(data[0]);
        nacc++;
      end
    end
    valid[0] = 1'b0;
    for (int t = 0; t < 800 && busy[0]; t++) tick();
    check("rand_drain", busy[0], 0);
    check("rand_some_accepted", (nacc != 0), 1);
    check("rand_queue_empty", q_exp.size(), 0);
    check("rand_tx_idle", tx[0], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
